// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU op enum, ALUOp encodings and R-type funct constants.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Operation selected by the decoder; INVALID_OP covers every undecodable case
   typedef enum logic [2:0] {
      ADD        = 3'd0,
      SUB        = 3'd1,
      MUL        = 3'd2,
      AND        = 3'd3,
      OR         = 3'd4,
      INVALID_OP = 3'd5
   } alu_op_e;

   // ALUOp op-class encodings
   localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] c_ALUOP_RSVD  = 2'b10;
   localparam logic [1:0] c_ALUOP_RTYPE = 2'b11;

   // R-type function codes
   localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
   localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
   localparam logic [5:0] c_FUNCT_MUL = 6'b011000;
   localparam logic [5:0] c_FUNCT_AND = 6'b100100;
   localparam logic [5:0] c_FUNCT_OR  = 6'b100101;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode
// Brief    : Combinational decode of ALUOp/funct into an ALU operation.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode
   import alu_pkg::*;
(
   input  logic [1:0] ALUOp_i,
   input  logic [5:0] funct_i,
   output alu_op_e    op_o
);

   // Op class first; R-type falls through to the funct table
   always_comb begin
      op_o = INVALID_OP;
      case (ALUOp_i)
         c_ALUOP_ADD:   op_o = ADD;
         c_ALUOP_SUB:   op_o = SUB;
         c_ALUOP_RTYPE: begin
            case (funct_i)
               c_FUNCT_ADD: op_o = ADD;
               c_FUNCT_SUB: op_o = SUB;
               c_FUNCT_MUL: op_o = MUL;
               c_FUNCT_AND: op_o = AND;
               c_FUNCT_OR:  op_o = OR;
               default:     op_o = INVALID_OP;
            endcase
         end
         default:       op_o = INVALID_OP;
      endcase
   end

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Single-issue ALU with valid/ready handshakes; single-cycle
//            ADD/SUB/AND/OR, iterative shift-add MUL (one bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       ALUOp_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             invalid_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic             r_invalid;

   alu_op_e          w_op;
   logic [WIDTH-1:0] w_alu_result;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_accept;
   logic             w_mul_last;

   alu_decode u_decode (
      .ALUOp_i (ALUOp_i),
      .funct_i (funct_i),
      .op_o    (w_op)
   );

   assign w_accept   = valid_i && (r_state == S_IDLE);
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Single-cycle result for every non-MUL op; undecodable requests yield zero
   always_comb begin
      w_alu_result = '0;
      case (w_op)
         ADD:     w_alu_result = data1_i + data2_i;
         SUB:     w_alu_result = data1_i - data2_i;
         AND:     w_alu_result = data1_i & data2_i;
         OR:      w_alu_result = data1_i | data2_i;
         default: w_alu_result = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)   w_state_nxt = (w_op == MUL) ? S_MUL : S_DONE;
         S_MUL:   if (w_mul_last) w_state_nxt = S_DONE;
         S_DONE:  if (ready_i)    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready_o = (r_state == S_IDLE);
      valid_o = (r_state == S_DONE);
   end

   // Datapath: operand capture, shift-add iterations and result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_data    <= '0;
         r_zero    <= 1'b0;
         r_invalid <= 1'b0;
      end else if (w_accept) begin
         if (w_op == MUL) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else begin
            r_data    <= w_alu_result;
            r_zero    <= (w_alu_result == '0);
            r_invalid <= (w_op == INVALID_OP);
         end
      end else if (r_state == S_MUL) begin
         // Multiplicand walks left, multiplier right; bits past WIDTH drop off
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + c_CNT_ONE;
         if (w_mul_last) begin
            r_data    <= w_acc_next;
            r_zero    <= (w_acc_next == '0);
            r_invalid <= 1'b0;
         end
      end
   end

   assign data_o    = r_data;
   assign zero_o    = r_zero;
   assign invalid_o = r_invalid;

endmodule : alu_exec_unit
`default_nettype wire
